// File: rtl/cell_pos_streamer.sv
// cell_pos_streamer: read master for one position cell RAM.
// Fetches the particle count at addr 0, then streams positions
// 1..count over valid/ready through a small credit-managed FIFO.
// Ports: clk, rst_n (async, active-low), start;
//   RAM side: ram_addr, ram_rden, ram_q (2-cycle read latency);
//   stream side: out_data, out_valid, out_ready, out_last;
//   status: busy, done, count (clamped particle count).
// Optional: define CELL_STREAM_PID_EN to add out_pid, the RAM
//   address (1..count) of the beat at the FIFO head.
module cell_pos_streamer #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_rden,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
`ifdef CELL_STREAM_PID_EN
  output logic [ADDR_WIDTH-1:0] out_pid,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] MAXC =
    ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {
    IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, DONE
  } state_e;

  state_e                state_q;
  logic                  rden_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  busy_q;
  logic                  done_q;
  logic [ADDR_WIDTH-1:0] count_q;
  logic [ADDR_WIDTH-1:0] na_q;
  logic                  wait_q;

  // Read-return tracking: one stage per cycle of RAM latency.
  logic                  p1_q;
  logic                  p2_q;
  logic [ADDR_WIDTH-1:0] p1_addr_q;
  logic [ADDR_WIDTH-1:0] p2_addr_q;

  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic                  mem_last [FIFO_DEPTH];
`ifdef CELL_STREAM_PID_EN
  logic [ADDR_WIDTH-1:0] mem_pid  [FIFO_DEPTH];
`endif
  logic [PW-1:0]         wr_q;
  logic [PW-1:0]         rd_q;
  logic [OW-1:0]         occ_q;

  logic                  push;
  logic                  pop;
  logic                  empty;
  logic                  in_flight;
  logic [OW:0]           used;
  logic                  credit_ok;
  logic [ADDR_WIDTH-1:0] cnt_raw;
  logic [ADDR_WIDTH-1:0] cnt_clamp;

  assign push      = p2_q;
  assign empty     = (occ_q == '0);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign in_flight = rden_q | p1_q | p2_q;

  // A slot freed by this cycle's pop may be reused by the next
  // read, which keeps one beat per cycle with a 4-entry FIFO.
  assign used = (OW+1)'(occ_q) + (OW+1)'(rden_q)
              + (OW+1)'(p1_q) + (OW+1)'(p2_q);
  assign credit_ok =
    (used - (OW+1)'(pop)) < (OW+1)'(FIFO_DEPTH);

  assign cnt_raw   = ram_q[ADDR_WIDTH-1:0];
  assign cnt_clamp = (cnt_raw > MAXC) ? MAXC : cnt_raw;

  assign ram_rden = rden_q;
  assign ram_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;

  // Head is masked so stale entries never leak when empty.
  assign out_data = empty ? '0 : mem_data[rd_q];
  assign out_last = !empty && mem_last[rd_q];
`ifdef CELL_STREAM_PID_EN
  assign out_pid  = empty ? '0 : mem_pid[rd_q];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rden_q  <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      na_q    <= '0;
      wait_q  <= 1'b0;
    end else begin
      rden_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RD_CNT;
            busy_q  <= 1'b1;
            rden_q  <= 1'b1;
            addr_q  <= '0;
          end
        end
        RD_CNT: begin
          state_q <= WAIT_CNT;
          wait_q  <= 1'b0;
        end
        WAIT_CNT: begin
          if (!wait_q) begin
            wait_q <= 1'b1;
          end else begin
            count_q <= cnt_clamp;
            na_q    <= ADDR_WIDTH'(1);
            if (cnt_clamp == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= STREAM;
            end
          end
        end
        STREAM: begin
          if (credit_ok) begin
            rden_q <= 1'b1;
            addr_q <= na_q;
            na_q   <= na_q + ADDR_WIDTH'(1);
            if (na_q == count_q) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_last && !in_flight) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q      <= 1'b0;
      p2_q      <= 1'b0;
      p1_addr_q <= '0;
      p2_addr_q <= '0;
    end else begin
      p1_q      <= rden_q && (addr_q != '0);
      p2_q      <= p1_q;
      p1_addr_q <= addr_q;
      p2_addr_q <= p1_addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_last[i] <= 1'b0;
`ifdef CELL_STREAM_PID_EN
        mem_pid[i]  <= '0;
`endif
      end
    end else begin
      if (push) begin
        mem_data[wr_q] <= ram_q;
        mem_last[wr_q] <= (p2_addr_q == count_q);
`ifdef CELL_STREAM_PID_EN
        mem_pid[wr_q]  <= p2_addr_q;
`endif
        wr_q <= wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + OW'(1);
        2'b01:   occ_q <= occ_q - OW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && !pop && occ_q == OW'(FIFO_DEPTH)));

endmodule
